mem_arbiter: RTL and testbench

//  Shares one single-port memory/bus slave between two masters: M0 = core (IF fetch + load/store

---
 rtl/mem_arbiter_pkg.sv | 5 +
 rtl/mem_arbiter_pick.sv | 19 +
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: FSM encodings and master ids shared by the arbiter and its picker
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_DONE} arb_state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_t;
endpackage

// File: rtl/mem_arbiter_pick.sv
// mem_arbiter_pick: two-input one-hot grant picker; ARB_ROUND_ROBIN_EN selects alternating tie-break
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  master_t    last_gnt,
`endif
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] gnt
);
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    gnt = (req0 && req1) ? ((last_gnt == M0) ? 2'b10 : 2'b01) : {req1, req0};
`else
    gnt = req0 ? 2'b01 : {req1, 1'b0};
`endif
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory slave between core (M0) and debug/DMA (M1) masters
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority M0 > M1
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_done,
  output logic            m0_err,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_stall,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_done,
  output logic            m1_err,
  output logic [DW-1:0]   m1_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
  localparam bit WDOG_EN = TIMEOUT != 0;
  arb_state_t state, state_nx;
  master_t owner;
  logic [7:0] wdog;
  logic err_q, grant, busy, rd_hit, fin, tmo;
  logic [1:0] gnt;
`ifdef ARB_ROUND_ROBIN_EN
  master_t last_gnt;
`endif
  mem_arbiter_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .last_gnt(last_gnt),
`endif
    .req0(m0_req & ~m0_done),
    .req1(m1_req & ~m1_done),
    .gnt (gnt)
  );
  assign m0_done  = (state == ARB_DONE) && (owner == M0);
  assign m1_done  = (state == ARB_DONE) && (owner == M1);
  assign m0_err   = m0_done && err_q;
  assign m1_err   = m1_done && err_q;
  assign m0_stall = m0_req & ~m0_done;
  assign mem_req  = state == ARB_REQ;
  always_comb begin
    busy     = (state == ARB_REQ) || (state == ARB_RESP);
    grant    = (state == ARB_IDLE) && (|gnt);
    rd_hit   = mem_rvalid && ((state == ARB_RESP) || ((state == ARB_REQ) && mem_ready && !mem_we));
    fin      = rd_hit || ((state == ARB_REQ) && mem_ready && mem_we);
    tmo      = WDOG_EN && busy && !fin && (wdog == WDOG_LAST);
    state_nx = grant ? ARB_REQ :
               (fin || tmo) ? ARB_DONE :
               ((state == ARB_REQ) && mem_ready) ? ARB_RESP :
               (state == ARB_DONE) ? ARB_IDLE : state;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ARB_IDLE;
      owner     <= M0;
      wdog      <= 8'd0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt  <= M1;
`endif
    end else begin
      state <= state_nx;
      wdog  <= busy ? wdog + 8'd1 : 8'd0;
      if (grant) begin
        owner     <= gnt[1] ? M1 : M0;
        mem_we    <= gnt[1] ? m1_we : m0_we;
        mem_addr  <= gnt[1] ? m1_addr : m0_addr;
        mem_wdata <= gnt[1] ? m1_wdata : m0_wdata;
        mem_be    <= gnt[1] ? m1_be : m0_be;
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt  <= gnt[1] ? M1 : M0;
`endif
      end
      if (fin || tmo) err_q <= tmo;
      // aborted reads return zero so a stale value is never mistaken for data
      if ((rd_hit || tmo) && owner == M0) m0_rdata <= tmo ? '0 : mem_rdata;
      if ((rd_hit || tmo) && owner == M1) m1_rdata <= tmo ? '0 : mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (TIMEOUT=8)
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_done, m0_err, m0_stall, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  int passed = 0;
  int total = 0;
  logic first;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    {m0_req, m0_we, m1_req, m1_we, mem_ready, mem_rvalid} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata} = '0;
    {m0_be, m1_be} = '0;
    cyc();
    cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_m0_done", m0_done, 0);
    chk("rst_m1_done", m1_done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_stall", m0_stall, 0);
    rstn = 1'b1;
    cyc();
    // 1: zero-wait read, done at N+2
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    #1 chk("t1_stall_n", m0_stall, 1);
    chk("t1_mem_req_n", mem_req, 0);
    cyc();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_done_early", m0_done, 0);
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    cyc();
    chk("t1_done", m0_done, 1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_err", m0_err, 0);
    chk("t1_mem_req_off", mem_req, 0);
    chk("t1_stall_off", m0_stall, 0);
    m0_req = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    cyc();
    chk("t1_done_once", m0_done, 0);
    chk("t1_rdata_hold", m0_rdata, 32'hDEADBEEF);
    // 2: simultaneous requests
`ifdef ARB_ROUND_ROBIN_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    m0_req = 1; m0_we = 1; m0_addr = 32'h200; m0_wdata = 32'h2; m0_be = 4'hF;
    m1_req = 1; m1_we = 1; m1_addr = 32'h300; m1_wdata = 32'h3; m1_be = 4'hF;
    cyc();
    chk("t2_first_addr", mem_addr, first ? 32'h300 : 32'h200);
    chk("t2_first_wdata", mem_wdata, first ? 32'h3 : 32'h2);
    mem_ready = 1;
    cyc();
    chk("t2_first_m0_done", m0_done, !first);
    chk("t2_first_m1_done", m1_done, first);
    if (first) m1_req = 0; else m0_req = 0;
    mem_ready = 0;
    cyc();
    cyc();
    chk("t2_second_req", mem_req, 1);
    chk("t2_second_addr", mem_addr, first ? 32'h200 : 32'h300);
    mem_ready = 1;
    cyc();
    chk("t2_second_m0_done", m0_done, first);
    chk("t2_second_m1_done", m1_done, !first);
    m0_req = 0; m1_req = 0; mem_ready = 0;
    cyc();
    // 3: M1 write with 3 wait states
    m1_req = 1; m1_we = 1; m1_addr = 32'h400; m1_wdata = 32'h55AA00FF; m1_be = 4'h9;
    cyc();
    chk("t3_wdata", mem_wdata, 32'h55AA00FF);
    chk("t3_be", mem_be, 32'h9);
    chk("t3_we", mem_we, 1);
    chk("t3_stall", m0_stall, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_mem_req_hold", mem_req, 1);
      chk("t3_no_done", m1_done, 0);
      if (i == 3) mem_ready = 1;
      if (i < 3) cyc();
    end
    cyc();
    chk("t3_done", m1_done, 1);
    chk("t3_err", m1_err, 0);
    chk("t3_mem_req_off", mem_req, 0);
    m1_req = 0; mem_ready = 0;
    cyc();
    chk("t3_done_once", m1_done, 0);
    // 4: read accepted, data 5 cycles later
    m0_req = 1; m0_we = 0; m0_addr = 32'h500;
    cyc();
    chk("t4_mem_req", mem_req, 1);
    mem_ready = 1;
    cyc();
    mem_ready = 0;
    chk("t4_resp_req_low", mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_wait_req_low", mem_req, 0);
      chk("t4_wait_no_done", m0_done, 0);
    end
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    cyc();
    chk("t4_done", m0_done, 1);
    chk("t4_rdata", m0_rdata, 32'h12345678);
    chk("t4_err", m0_err, 0);
    m0_req = 0; mem_rvalid = 0; mem_rdata = 0;
    cyc();
    // 5: watchdog abort after 8 cycles
    m0_req = 1; m0_we = 0; m0_addr = 32'h600;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t5_req_held", mem_req, 1);
      chk("t5_no_done", m0_done, 0);
    end
    cyc();
    chk("t5_done", m0_done, 1);
    chk("t5_err", m0_err, 1);
    chk("t5_rdata_zero", m0_rdata, 0);
    chk("t5_mem_req_off", mem_req, 0);
    m0_req = 0;
    cyc();
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    chk("t5_idle_no_done", m0_done, 0);
    cyc();
    chk("t5_late_rvalid", m0_rdata, 0);
    chk("t5_idle_req", mem_req, 0);
    mem_rvalid = 0; mem_rdata = 0;
    // 6: async reset during RESP
    m0_req = 1; m0_we = 0; m0_addr = 32'h700;
    cyc();
    mem_ready = 1;
    cyc();
    mem_ready = 0;
    chk("t6_in_resp", mem_req, 0);
    #1 rstn = 0;
    #1 chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_done", m0_done, 0);
    chk("t6_rst_rdata", m0_rdata, 0);
    m0_req = 0;
    mem_rvalid = 1; mem_rdata = 32'h0BADCAFE;
    cyc();
    chk("t6_rst_held_done", m0_done, 0);
    mem_rvalid = 0;
    rstn = 1;
    cyc();
    chk("t6_post_no_done", m0_done, 0);
    chk("t6_post_rdata", m0_rdata, 0);
    m0_req = 1; m0_we = 0; m0_addr = 32'h800;
    cyc();
    chk("t6_new_req", mem_req, 1);
    chk("t6_new_addr", mem_addr, 32'h800);
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    cyc();
    chk("t6_new_done", m0_done, 1);
    chk("t6_new_rdata", m0_rdata, 32'hCAFEF00D);
    m0_req = 0; mem_ready = 0; mem_rvalid = 0;
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
